data_ram_ctrl: RTL and testbench
================================

Name: data_ram_ctrl

Overview:
Parametrised single-port data RAM for the CPU data path. It replaces the fixed 16-bit DataRAM with configurable width and depth, a registered read with a valid strobe, and a hardware zero-fill sequencer that runs after reset or on request. Out-of-range accesses are detected rather than aliased. It sits between the execute/memory stage and data storage.

Parameters:
DATA_W, 16, data word width in bits.
ADDR_W, 16, address bus width in bits.
DEPTH, 64, number of words; legal range 2..2^ADDR_W.
CNT_W, $clog2(DEPTH), width of the clear counter (derived).

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
RST  input  1  synchronous reset, active-high.
DataAddress  input  ADDR_W  word address for read/write.
MemWrite  input  1  write request this cycle.
MemRead  input  1  read request this cycle.
DataIn  input  DATA_W  write data.
ClearReq  input  1  request a zero-fill of the whole array.
DataOut  output  DATA_W  registered read data.
DataValid  output  1  one-cycle strobe; DataOut was updated by a read.
AddrErr  output  1  one-cycle strobe; the access in the previous cycle was out of range.
Busy  output  1  zero-fill in progress; requests are ignored.

Behaviour:
- One clock (CLK). Reset is synchronous and active-high: RST is sampled only at the CLK rising edge.
- On a cycle with RST=1:
  - state<=CLEAR, clr_cnt<=0.
  - DataOut<=0, DataValid<=0, AddrErr<=0, Busy<=1.
  - If RST is held high, the block stays in CLEAR with clr_cnt=0.
- FSM has two states: CLEAR and READY.
- CLEAR:
  - Each cycle writes 0 to mem[clr_cnt] and increments clr_cnt.
  - The cycle that writes DEPTH-1 moves the FSM to READY; Busy is 0 from the next cycle.
  - Total Busy time after RST deasserts is exactly DEPTH cycles.
  - MemWrite, MemRead and ClearReq are ignored: no write, no DataValid, no AddrErr, nothing queued.
  - DataOut holds its value.
- READY, in-range address (DataAddress < DEPTH; full ADDR_W compare, no truncation):
  - MemWrite=1: mem[DataAddress]<=DataIn at the edge.
  - MemRead=1: DataOut<=mem[DataAddress] at the edge, and DataValid=1 for that following cycle. Read latency is 1 cycle.
  - MemRead and MemWrite both set (same address by construction): write-first, so DataOut<=DataIn.
  - Back-to-back reads give one DataValid per read. With no read, DataValid=0 and DataOut holds its last value.
- READY, out-of-range address (DataAddress >= DEPTH) with MemRead or MemWrite set:
  - Any write is suppressed.
  - A read loads DataOut<=0 with DataValid=1.
  - AddrErr=1 for one cycle, aligned with where DataValid would be.
- ClearReq in READY:
  - Next state is CLEAR, clr_cnt<=0, Busy<=1 next cycle.
  - ClearReq wins over a simultaneous MemWrite/MemRead; the access is dropped with no DataValid or AddrErr.
- RST during CLEAR restarts the fill at clr_cnt=0.
- RST overrides ClearReq and all accesses.
- Array contents are undefined only before the first completed clear; the bench must not read before Busy falls.

Test Plan:
1. RST=1 for 2 cycles, then 0 (DEPTH=64) -> Busy=1 for exactly 64 cycles then 0; reads of addresses 0, 31, 63 return 0x0000 with DataValid=1 one cycle after each request.
2. Write 0xFFFF to addr 1, then read addr 1 -> DataOut=0xFFFF, DataValid=1 on the cycle after the read; read addr 32 -> 0x0000.
3. MemWrite 0x1234 to addr 5 while Busy=1 -> ignored, AddrErr=0, DataValid=0; after Busy falls, read addr 5 -> 0x0000.
4. Same-cycle MemWrite=1, MemRead=1 to addr 7 with DataIn=0xBEEF -> next cycle DataOut=0xBEEF, DataValid=1; a later read of 7 -> 0xBEEF.
5. Write 0xAAAA to addr 100, then read addr 100 and read addr 36 -> each out-of-range access gives AddrErr=1 one cycle later; read of 100 gives DataOut=0x0000, DataValid=1; read of 36 -> 0x0000 (no aliasing).
6. Write 0x5555 to addrs 0..3, pulse ClearReq together with a MemWrite to addr 4, then assert RST at clear cycle 10 -> write dropped, Busy stays 1 for 64 cycles after RST falls, and all of addrs 0..4 read 0x0000.

Source files
------------

// File: rtl/data_ram_ctrl.sv
// Parametrised single-port data RAM for the CPU data path.
// Registered read with a valid strobe, range-checked accesses, and a zero-fill
// sequencer that sweeps the whole array after reset or on ClearReq.
module data_ram_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned CNT_W  = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] DataAddress,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              ClearReq,
    output logic [DATA_W-1:0] DataOut,
    output logic              DataValid,
    output logic              AddrErr,
    output logic              Busy
);

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]  DepthLimit = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] LastIdx    = CNT_W'(DEPTH - 1);

    typedef enum logic {StClear, StReady} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [CNT_W-1:0]  r_clr_cnt;
    logic [CNT_W-1:0]  w_clr_cnt_next;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_data_out;
    logic              r_data_valid;
    logic              r_addr_err;

    logic              w_in_range;
    logic [CNT_W-1:0]  w_idx;
    logic              w_mem_we;
    logic [CNT_W-1:0]  w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_rd_hit;
    logic              w_rd_miss;
    logic              w_acc_err;

    assign w_in_range = {1'b0, DataAddress} < DepthLimit;
    // Only used when w_in_range holds, so the upper address bits are zero.
    assign w_idx      = DataAddress[CNT_W-1:0];

    // State register and clear counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= StClear;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
        end
    end

    // Next-state, memory write port selection and access decode.
    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        w_mem_we       = 1'b0;
        w_mem_addr     = r_clr_cnt;
        w_mem_wdata    = '0;
        w_rd_hit       = 1'b0;
        w_rd_miss      = 1'b0;
        w_acc_err      = 1'b0;
        if (RST) begin
            w_state_next   = StClear;
            w_clr_cnt_next = '0;
        end else begin
            unique case (r_state)
                StClear: begin
                    w_mem_we = 1'b1;
                    if (r_clr_cnt == LastIdx) begin
                        w_state_next   = StReady;
                        w_clr_cnt_next = '0;
                    end else begin
                        w_clr_cnt_next = r_clr_cnt + CNT_W'(1);
                    end
                end
                StReady: begin
                    if (ClearReq) begin
                        // Clear wins; any same-cycle access is dropped.
                        w_state_next   = StClear;
                        w_clr_cnt_next = '0;
                    end else if (w_in_range) begin
                        w_mem_we    = MemWrite;
                        w_mem_addr  = w_idx;
                        w_mem_wdata = DataIn;
                        w_rd_hit    = MemRead;
                    end else begin
                        w_rd_miss = MemRead;
                        w_acc_err = MemRead | MemWrite;
                    end
                end
                default: begin
                    w_state_next   = StClear;
                    w_clr_cnt_next = '0;
                end
            endcase
        end
    end

    // Storage array; no reset, contents defined by the clear sweep.
    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Registered read data and one-cycle status strobes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_addr_err   <= 1'b0;
        end else begin
            r_data_valid <= w_rd_hit | w_rd_miss;
            r_addr_err   <= w_acc_err;
            if (w_rd_hit) begin
                // Write-first on a simultaneous read/write.
                r_data_out <= MemWrite ? DataIn : r_mem[w_idx];
            end else if (w_rd_miss) begin
                r_data_out <= '0;
            end
        end
    end

    assign DataOut   = r_data_out;
    assign DataValid = r_data_valid;
    assign AddrErr   = r_addr_err;
    assign Busy      = (r_state == StClear);

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Directed self-checking bench for data_ram_ctrl (DEPTH=64, DATA_W=16).
module tb_data_ram_ctrl;

    logic        CLK;
    logic        RST;
    logic [15:0] DataAddress;
    logic        MemWrite;
    logic        MemRead;
    logic [15:0] DataIn;
    logic        ClearReq;
    logic [15:0] DataOut;
    logic        DataValid;
    logic        AddrErr;
    logic        Busy;

    int n_total;
    int n_pass;
    int busy_cnt;
    logic busy_strobe;

    data_ram_ctrl #(
        .DATA_W(16),
        .ADDR_W(16),
        .DEPTH (64)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .DataAddress(DataAddress),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .DataIn     (DataIn),
        .ClearReq   (ClearReq),
        .DataOut    (DataOut),
        .DataValid  (DataValid),
        .AddrErr    (AddrErr),
        .Busy       (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic rd(input string tag, input logic [15:0] addr, input logic [15:0] exp,
                      input logic exp_err);
        DataAddress = addr;
        MemRead     = 1'b1;
        tick();
        MemRead     = 1'b0;
        check({tag, ".data"}, 32'(DataOut), 32'(exp));
        check({tag, ".valid"}, 32'(DataValid), 32'd1);
        check({tag, ".err"}, 32'(AddrErr), 32'(exp_err));
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data);
        DataAddress = addr;
        DataIn      = data;
        MemWrite    = 1'b1;
        tick();
        MemWrite    = 1'b0;
    endtask

    // Counts Busy cycles (bounded) and flags any strobe seen while busy.
    task automatic count_busy();
        busy_cnt    = 0;
        busy_strobe = 1'b0;
        while (Busy && busy_cnt < 200) begin
            tick();
            busy_cnt++;
            if (DataValid || AddrErr) busy_strobe = 1'b1;
        end
    endtask

    initial begin
        n_total     = 0;
        n_pass      = 0;
        RST         = 1'b1;
        DataAddress = '0;
        MemWrite    = 1'b0;
        MemRead     = 1'b0;
        DataIn      = '0;
        ClearReq    = 1'b0;

        // Reset for two cycles.
        tick();
        tick();
        check("rst.busy", 32'(Busy), 32'd1);
        check("rst.valid", 32'(DataValid), 32'd0);
        check("rst.err", 32'(AddrErr), 32'd0);
        check("rst.data", 32'(DataOut), 32'd0);
        RST = 1'b0;

        // Hammer requests while the initial fill runs; all must be ignored.
        DataAddress = 16'd5;
        DataIn      = 16'h1234;
        MemWrite    = 1'b1;
        MemRead     = 1'b1;
        ClearReq    = 1'b1;
        count_busy();
        MemWrite    = 1'b0;
        MemRead     = 1'b0;
        ClearReq    = 1'b0;
        check("init.busy_cycles", 32'(busy_cnt), 32'd64);
        check("init.no_strobe", 32'(busy_strobe), 32'd0);

        rd("init.rd0", 16'd0, 16'h0000, 1'b0);
        rd("init.rd31", 16'd31, 16'h0000, 1'b0);
        rd("init.rd63", 16'd63, 16'h0000, 1'b0);
        rd("busywr.rd5", 16'd5, 16'h0000, 1'b0);

        // Basic write/read.
        wr(16'd1, 16'hFFFF);
        check("wr1.novalid", 32'(DataValid), 32'd0);
        rd("rd1", 16'd1, 16'hFFFF, 1'b0);
        rd("rd32", 16'd32, 16'h0000, 1'b0);

        // Idle cycle: no strobe, data held.
        wr(16'd9, 16'h0F0F);
        tick();
        check("idle.valid", 32'(DataValid), 32'd0);
        check("idle.hold", 32'(DataOut), 32'h0000);
        rd("rd9", 16'd9, 16'h0F0F, 1'b0);

        // Simultaneous read/write is write-first.
        DataAddress = 16'd7;
        DataIn      = 16'hBEEF;
        MemWrite    = 1'b1;
        MemRead     = 1'b1;
        tick();
        MemWrite    = 1'b0;
        MemRead     = 1'b0;
        check("rw7.data", 32'(DataOut), 32'hBEEF);
        check("rw7.valid", 32'(DataValid), 32'd1);
        rd("rd7", 16'd7, 16'hBEEF, 1'b0);

        // Out-of-range accesses.
        wr(16'd100, 16'hAAAA);
        check("oor.wr.err", 32'(AddrErr), 32'd1);
        check("oor.wr.valid", 32'(DataValid), 32'd0);
        rd("oor.rd100", 16'd100, 16'h0000, 1'b1);
        rd("alias.rd36", 16'd36, 16'h0000, 1'b0);
        rd("edge.rd64", 16'd64, 16'h0000, 1'b1);
        rd("edge.rd_hi", 16'h8000, 16'h0000, 1'b1);

        // ClearReq beats a write, then RST restarts the fill mid-sweep.
        for (int i = 0; i < 4; i++) wr(16'(i), 16'h5555);
        rd("pre.rd2", 16'd2, 16'h5555, 1'b0);
        DataAddress = 16'd4;
        DataIn      = 16'h5555;
        MemWrite    = 1'b1;
        ClearReq    = 1'b1;
        tick();
        MemWrite    = 1'b0;
        ClearReq    = 1'b0;
        check("clr.busy", 32'(Busy), 32'd1);
        check("clr.valid", 32'(DataValid), 32'd0);
        check("clr.err", 32'(AddrErr), 32'd0);
        for (int i = 0; i < 10; i++) tick();
        check("clr.mid_busy", 32'(Busy), 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("clr.rst_data", 32'(DataOut), 32'd0);
        count_busy();
        check("clr.busy_cycles", 32'(busy_cnt), 32'd64);
        for (int i = 0; i < 5; i++) rd("clr.rd", 16'(i), 16'h0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
